// File: rtl/ecc_operand_loader.sv
// ecc_operand_loader: deserialises nibble streams into range-checked, double-buffered ECC operands
module ecc_operand_loader #(
  parameter int SIZE = 32,
  parameter int NIB = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [NIB-1:0]  a,
  input  logic [NIB-1:0]  prime,
  input  logic [NIB-1:0]  k,
  input  logic [NIB-1:0]  Px,
  input  logic [NIB-1:0]  Py,
  input  logic            i_core_busy,
  output logic [SIZE-1:0] o_a,
  output logic [SIZE-1:0] o_prime,
  output logic [SIZE-1:0] o_k,
  output logic [SIZE-1:0] o_px,
  output logic [SIZE-1:0] o_py,
  output logic            o_valid,
  output logic            o_param_err,
  output logic            o_core_start,
  output logic            o_loading,
  output logic            o_restart
);
  localparam int NUM_NIB = SIZE / NIB;
  localparam int CW = (NUM_NIB > 2) ? $clog2(NUM_NIB) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SIZE-1:0] sw_a, sw_p, sw_k, sw_x, sw_y;
  logic [SIZE-1:0] f_a, f_p, f_k, f_x, f_y;
  logic [SIZE-1:0] s_a, s_p, s_k, s_x, s_y;
  logic last, shift, commit, err, pend;
  assign f_a = {sw_a[SIZE-NIB-1:0], a};
  assign f_p = {sw_p[SIZE-NIB-1:0], prime};
  assign f_k = {sw_k[SIZE-NIB-1:0], k};
  assign f_x = {sw_x[SIZE-NIB-1:0], Px};
  assign f_y = {sw_y[SIZE-NIB-1:0], Py};
  assign pend = state == PENDING;
  assign last = state == LOAD && cnt == CW'(NUM_NIB - 1);
  assign shift = (state == IDLE && i_start) || state == LOAD;
  assign commit = !i_core_busy && (last || pend);
  // in PENDING the completed words already sit in the shift registers
  assign s_a = pend ? sw_a : f_a;
  assign s_p = pend ? sw_p : f_p;
  assign s_k = pend ? sw_k : f_k;
  assign s_x = pend ? sw_x : f_x;
  assign s_y = pend ? sw_y : f_y;
  assign err = !s_p[0] || s_p < SIZE'(5) || s_a >= s_p || s_x >= s_p || s_y >= s_p || s_k == '0;
  assign o_loading = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      {sw_a, sw_p, sw_k, sw_x, sw_y} <= '0;
      {o_a, o_prime, o_k, o_px, o_py} <= '0;
      {o_valid, o_param_err, o_core_start, o_restart} <= '0;
    end else begin
      if (shift) {sw_a, sw_p, sw_k, sw_x, sw_y} <= {f_a, f_p, f_k, f_x, f_y};
      if (commit) {o_a, o_prime, o_k, o_px, o_py} <= {s_a, s_p, s_k, s_x, s_y};
      o_valid <= commit;
      o_param_err <= commit && err;
      o_core_start <= commit && !err;
      o_restart <= state == LOAD && !last && i_start;
      cnt <= state == IDLE ? (i_start ? CW'(1) : '0)
           : state == LOAD ? (last ? '0 : i_start ? CW'(1) : cnt + CW'(1))
           : '0;
      state <= state == IDLE ? (i_start ? LOAD : IDLE)
             : state == LOAD ? (last ? (i_core_busy ? PENDING : IDLE) : LOAD)
             : (i_core_busy ? PENDING : IDLE);
    end
  end
endmodule

// File: tb/tb_ecc_operand_loader.sv
// tb_ecc_operand_loader: directed stimulus checked against a word-level protocol model every cycle
module tb_ecc_operand_loader;
  logic i_clk = 0, i_rst = 1, i_start = 0, i_core_busy = 0;
  logic [3:0] a = 0, prime = 0, k = 0, Px = 0, Py = 0;
  logic [31:0] o_a, o_prime, o_k, o_px, o_py;
  logic o_valid, o_param_err, o_core_start, o_loading, o_restart;
  int errors = 0, checks = 0, restarts = 0, valids = 0;
  bit armed = 0;
  ecc_operand_loader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .a(a), .prime(prime), .k(k),
    .Px(Px), .Py(Py), .i_core_busy(i_core_busy), .o_a(o_a), .o_prime(o_prime), .o_k(o_k),
    .o_px(o_px), .o_py(o_py), .o_valid(o_valid), .o_param_err(o_param_err),
    .o_core_start(o_core_start), .o_loading(o_loading), .o_restart(o_restart)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit bad(longint p, longint aa, longint kk, longint x, longint y);
    return (p % 2 == 0) || p < 5 || aa >= p || x >= p || y >= p || kk == 0;
  endfunction
  // model: operand words as integers, n = nibbles gathered so far, pend = complete but waiting
  longint m_w[5];
  int m_n = 0;
  bit m_pend = 0;
  longint e_o[5];
  bit e_valid, e_err, e_start, e_restart, e_loading;
  always @(posedge i_clk) begin
    longint nib[5];
    bit done;
    nib = '{longint'(a), longint'(prime), longint'(k), longint'(Px), longint'(Py)};
    done = 0;
    e_valid = 0; e_err = 0; e_start = 0; e_restart = 0;
    if (i_rst) begin
      armed = 1; m_n = 0; m_pend = 0;
      foreach (m_w[i]) begin m_w[i] = 0; e_o[i] = 0; end
    end else if (m_pend) begin
      done = !i_core_busy;
    end else if (m_n == 0) begin
      if (i_start) begin
        foreach (m_w[i]) m_w[i] = nib[i];
        m_n = 1;
      end
    end else if (m_n == 7) begin
      foreach (m_w[i]) m_w[i] = (m_w[i] * 16 + nib[i]) % 64'h1_0000_0000;
      m_n = 0;
      if (i_core_busy) m_pend = 1; else done = 1;
    end else if (i_start) begin
      foreach (m_w[i]) m_w[i] = nib[i];
      m_n = 1;
      e_restart = 1;
    end else begin
      foreach (m_w[i]) m_w[i] = m_w[i] * 16 + nib[i];
      m_n++;
    end
    if (done) begin
      m_pend = 0;
      foreach (e_o[i]) e_o[i] = m_w[i];
      e_valid = 1;
      e_err = bad(m_w[1], m_w[0], m_w[2], m_w[3], m_w[4]);
      e_start = !e_err;
    end
    e_loading = m_n != 0 || m_pend;
  end
  always @(negedge i_clk) begin
    if (armed) begin
      chk("m_a", o_a, 32'(e_o[0]));
      chk("m_prime", o_prime, 32'(e_o[1]));
      chk("m_k", o_k, 32'(e_o[2]));
      chk("m_px", o_px, 32'(e_o[3]));
      chk("m_py", o_py, 32'(e_o[4]));
      chk("m_valid", 32'(o_valid), 32'(e_valid));
      chk("m_err", 32'(o_param_err), 32'(e_err));
      chk("m_start", 32'(o_core_start), 32'(e_start));
      chk("m_loading", 32'(o_loading), 32'(e_loading));
      chk("m_restart", 32'(o_restart), 32'(e_restart));
      if (o_restart) restarts++;
      if (o_valid) valids++;
    end
  end
  task automatic send(input logic [31:0] wa, wp, wk, wx, wy, input int from, input int n);
    for (int i = from; i < n; i++) begin
      i_start = (i == 0);
      a = wa[31-4*i -: 4];
      prime = wp[31-4*i -: 4];
      k = wk[31-4*i -: 4];
      Px = wx[31-4*i -: 4];
      Py = wy[31-4*i -: 4];
      @(posedge i_clk); #1;
    end
    i_start = 0; a = 0; prime = 0; k = 0; Px = 0; Py = 0;
  endtask
  task automatic expect_done(input string tag, input bit e, input logic [31:0] p);
    chk({tag, "_valid"}, 32'(o_valid), 1);
    chk({tag, "_err"}, 32'(o_param_err), 32'(e));
    chk({tag, "_start"}, 32'(o_core_start), 32'(!e));
    chk({tag, "_prime"}, o_prime, p);
  endtask
  int r0, v0;
  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_prime", o_prime, 0);
    chk("rst_loading", 32'(o_loading), 0);
    i_rst = 0;
    @(posedge i_clk); #1;
    send(1, 32'h17, 9, 3, 32'hA, 0, 8);
    expect_done("basic", 0, 32'h17);
    chk("basic_a", o_a, 1);
    chk("basic_k", o_k, 9);
    chk("basic_px", o_px, 3);
    chk("basic_py", o_py, 32'hA);
    repeat (2) @(posedge i_clk);
    #1;
    i_core_busy = 1;
    send(2, 32'h25, 3, 4, 5, 0, 8);
    chk("busy_novalid", 32'(o_valid), 0);
    chk("busy_loading", 32'(o_loading), 1);
    for (int j = 0; j < 5; j++) begin
      i_start = (j == 1 || j == 3);
      prime = 4'hF;
      @(posedge i_clk); #1;
    end
    i_start = 0; prime = 0;
    chk("busy_hold_prime", o_prime, 32'h17);
    chk("busy_hold_valid", 32'(o_valid), 0);
    i_core_busy = 0;
    @(posedge i_clk); #1;
    expect_done("busy", 0, 32'h25);
    chk("busy_a", o_a, 2);
    chk("busy_loading_end", 32'(o_loading), 0);
    send(1, 32'h16, 9, 3, 32'hA, 0, 8);
    expect_done("err_even", 1, 32'h16);
    send(1, 32'h17, 9, 32'h17, 32'hA, 0, 8);
    expect_done("err_px", 1, 32'h17);
    chk("err_px_px", o_px, 32'h17);
    send(1, 32'h17, 0, 3, 32'hA, 0, 8);
    expect_done("err_k0", 1, 32'h17);
    @(posedge i_clk); #1;
    r0 = restarts;
    send(32'h7777_7777, 32'h1F1F_1F1F, 32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 0, 3);
    send(1, 32'h17, 9, 3, 32'hA, 0, 8);
    expect_done("restart", 0, 32'h17);
    chk("restart_a", o_a, 1);
    chk("restart_k", o_k, 9);
    chk("restart_count", 32'(restarts - r0), 1);
    send(2, 32'h25, 3, 4, 5, 0, 4);
    i_rst = 1;
    @(posedge i_clk); #1;
    chk("mid_rst_prime", o_prime, 0);
    chk("mid_rst_a", o_a, 0);
    chk("mid_rst_loading", 32'(o_loading), 0);
    i_rst = 0;
    v0 = valids;
    repeat (12) @(posedge i_clk);
    #1;
    chk("mid_rst_no_valid", 32'(valids - v0), 0);
    send(1, 32'h17, 9, 3, 32'hA, 0, 8);
    expect_done("after_rst", 0, 32'h17);
    @(posedge i_clk); #1;
    send(1, 32'h17, 9, 3, 32'hA, 0, 8);
    expect_done("b2b_first", 0, 32'h17);
    send(2, 32'h25, 3, 4, 5, 0, 7);
    chk("b2b_stable_prime", o_prime, 32'h17);
    chk("b2b_stable_valid", 32'(o_valid), 0);
    send(2, 32'h25, 3, 4, 5, 7, 8);
    expect_done("b2b_second", 0, 32'h25);
    chk("b2b_py", o_py, 5);
    repeat (3) @(posedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
